// File: rtl/cpu_pkg.sv
// Shared opcode constants, sequencer state encoding and IR field helpers.
// Latency: none (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    localparam logic [2:0] OP_MOV  = 3'b110;
    localparam logic [2:0] OP_ALU  = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_READY,
        ST_START,
        ST_EXEC,
        ST_NEXT,
        ST_HALT
    } seq_state_e;

    function automatic logic [2:0] opcode_of(input logic [15:0] word);
        return word[15:13];
    endfunction

    function automatic logic [1:0] op_of(input logic [15:0] word);
        return word[12:11];
    endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Fetches instructions into the IR and issues each one to the controller over the s/w handshake.
// Latency: run high in IDLE with w=1 gives s=1 four edges later; at least 6 cycles per instruction.
// Backpressure: holds in READY while w=0 and in EXEC until w returns to 1; START gives up after TIMEOUT cycles.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic            mem_rd,
    output logic [PC_W-1:0] mem_addr,
    input  logic [15:0]     mem_rdata,
    output logic            s,
    input  logic            w,
    output logic [15:0]     instr,
    output logic [2:0]      opcode,
    output logic [1:0]      op,
    output logic [PC_W-1:0] pc,
    output logic [15:0]     retired,
    output logic            halted,
    output logic            err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    seq_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic [15:0]     retired_q, retired_d;
    logic            halted_q, halted_d;
    logic            err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and architectural registers; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            retired_q <= '0;
            halted_q  <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            halted_q  <= halted_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state logic: fetch, load, handshake with the controller, then retire.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        halted_d  = halted_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (run && !halted_q && !err_q) state_d = ST_FETCH;
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                ir_d    = mem_rdata;
                state_d = (opcode_of(mem_rdata) == OP_HALT) ? ST_HALT : ST_READY;
            end
            ST_READY: begin
                if (w) state_d = ST_START;
            end
            ST_START: begin
                // The counter holds the number of START cycles already spent,
                // so s stays high for exactly TIMEOUT cycles before giving up.
                if (!w) begin
                    state_d = ST_EXEC;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_EXEC: begin
                if (w) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                pc_d      = pc_q + 1'b1;
                retired_d = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;
                state_d   = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                halted_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_rd   = (state_q == ST_FETCH);
    assign mem_addr = pc_q;
    assign s        = (state_q == ST_START);
    assign instr    = ir_q;
    assign opcode   = opcode_of(ir_q);
    assign op       = op_of(ir_q);
    assign pc       = pc_q;
    assign retired  = retired_q;
    assign halted   = halted_q;
    assign err      = err_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed scenarios plus random programs against a program-level model.
// Latency: n/a.
// Backpressure: controller model and a hold-low override drive w.
module tb_instr_sequencer;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        mem_rd;
    logic [1:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        s;
    logic        w;
    logic [15:0] instr;
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [1:0]  pc;
    logic [15:0] retired;
    logic        halted;
    logic        err;

    logic [15:0] mem [4];
    logic        w_ctrl;
    logic        hold_low;
    logic        ctrl_never;
    int          exec_cyc;
    int          vectors = 0;
    int          miscompares = 0;

    instr_sequencer #(.PC_W(2), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .run(run),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .s(s), .w(w), .instr(instr), .opcode(opcode), .op(op),
        .pc(pc), .retired(retired), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    assign w = w_ctrl & ~hold_low;

    // Synchronous instruction memory, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    // Controller: drops w as soon as it sees s, stays busy exec_cyc edges, returns to wait.
    initial begin
        w_ctrl = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (s === 1'b1 && w_ctrl && !ctrl_never) begin
                w_ctrl = 1'b0;
                repeat (exec_cyc) @(posedge clk);
                #1 w_ctrl = 1'b1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed no end of run, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_s(input string tag);
        int n = 0;
        while (s !== 1'b1 && n < 100) begin tick(); n++; end
        check({tag, "_s_rise"}, {31'b0, s}, 32'd1);
    endtask

    task automatic wait_ret(input string tag, input int v);
        int n = 0;
        while (retired !== 16'(v) && n < 100) begin tick(); n++; end
        check({tag, "_retired"}, {16'b0, retired}, v);
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        while (halted !== 1'b1 && n < 100) begin tick(); n++; end
        check({tag, "_halted"}, {31'b0, halted}, 32'd1);
    endtask

    task automatic idle_quiet(input string tag, input int cycles);
        logic busy = 1'b0;
        repeat (cycles) begin
            tick();
            if (mem_rd !== 1'b0 || s !== 1'b0) busy = 1'b1;
        end
        check({tag, "_quiet"}, {31'b0, busy}, 32'd0);
    endtask

    // One issued instruction: the model predicts IR, PC and retired count at s.
    task automatic issue_one(input string tag, input logic [15:0] exp_instr,
                             input int exp_pc, input int exp_ret, input int exec);
        logic [15:0] e;
        e = exp_instr;
        exec_cyc = exec;
        wait_s(tag);
        check({tag, "_instr"}, {16'b0, instr}, {16'b0, e});
        check({tag, "_opcode"}, {29'b0, opcode}, {29'b0, e[15:13]});
        check({tag, "_op"}, {30'b0, op}, {30'b0, e[12:11]});
        check({tag, "_pc"}, {30'b0, pc}, exp_pc);
        check({tag, "_ret"}, {16'b0, retired}, exp_ret);
        tick();
        check({tag, "_s_one_cycle"}, {31'b0, s}, 32'd0);
    endtask

    task automatic reset_dut();
        run = 1'b0;
        hold_low = 1'b0;
        ctrl_never = 1'b0;
        reset = 1'b0;
        repeat (8) tick();
        reset = 1'b1;
        tick();
    endtask

    function automatic logic [15:0] rand_word();
        return {3'($urandom_range(0, 6)), 13'($urandom)};
    endfunction

    initial begin
        int hi;
        logic busy;
        int h;
        reset = 1'b0;
        run = 1'b0;
        hold_low = 1'b0;
        ctrl_never = 1'b0;
        exec_cyc = 3;
        for (int i = 0; i < 4; i++) mem[i] = 16'h0000;
        tick(); tick();

        // Reset values.
        check("rst_s", {31'b0, s}, 0);
        check("rst_mem_rd", {31'b0, mem_rd}, 0);
        check("rst_mem_addr", {30'b0, mem_addr}, 0);
        check("rst_pc", {30'b0, pc}, 0);
        check("rst_instr", {16'b0, instr}, 0);
        check("rst_opcode", {29'b0, opcode}, 0);
        check("rst_op", {30'b0, op}, 0);
        check("rst_retired", {16'b0, retired}, 0);
        check("rst_halted", {31'b0, halted}, 0);
        check("rst_err", {31'b0, err}, 0);

        // Basic issue, cycle by cycle from run rising.
        mem[0] = 16'hD105;
        reset = 1'b1;
        tick();
        run = 1'b1;
        tick();
        check("basic_mem_rd", {31'b0, mem_rd}, 1);
        check("basic_mem_addr", {30'b0, mem_addr}, 0);
        check("basic_s_fetch", {31'b0, s}, 0);
        tick();
        check("basic_s_load", {31'b0, s}, 0);
        tick();
        check("basic_s_ready", {31'b0, s}, 0);
        check("basic_ir", {16'b0, instr}, 32'hD105);
        tick();
        check("basic_latency_s", {31'b0, s}, 1);
        check("basic_opcode", {29'b0, opcode}, {29'b0, OP_MOV});
        check("basic_op", {30'b0, op}, 32'd2);
        run = 1'b0;
        tick();
        check("basic_s_one_cycle", {31'b0, s}, 0);
        wait_ret("basic", 1);
        check("basic_pc", {30'b0, pc}, 1);
        idle_quiet("basic_stop", 8);

        // Sequential program ending in HALT.
        reset_dut();
        mem[0] = 16'hD001; mem[1] = 16'hA0A0; mem[2] = 16'hE000; mem[3] = 16'hD001;
        run = 1'b1;
        issue_one("seq0", 16'hD001, 0, 0, 2);
        check("seq0_opcode_mov", {29'b0, opcode}, {29'b0, OP_MOV});
        issue_one("seq1", 16'hA0A0, 1, 1, 3);
        check("seq1_opcode_alu", {29'b0, opcode}, {29'b0, OP_ALU});
        wait_halt("seq");
        check("seq_pc", {30'b0, pc}, 2);
        check("seq_retired", {16'b0, retired}, 2);
        check("seq_halt_opcode", {29'b0, opcode}, {29'b0, OP_HALT});
        idle_quiet("seq_halted", 20);
        run = 1'b0;

        // Backpressure: w held low while the sequencer waits in READY.
        reset_dut();
        mem[0] = 16'hD105;
        hold_low = 1'b1;
        run = 1'b1;
        repeat (3) tick();
        busy = 1'b0;
        repeat (5) begin
            tick();
            if (s !== 1'b0) busy = 1'b1;
        end
        check("bp_s_held_low", {31'b0, busy}, 0);
        hold_low = 1'b0;
        tick();
        check("bp_s_after_w", {31'b0, s}, 1);
        run = 1'b0;
        tick();
        check("bp_s_drop", {31'b0, s}, 0);
        wait_ret("bp", 1);

        // Timeout: controller never acknowledges.
        reset_dut();
        ctrl_never = 1'b1;
        run = 1'b1;
        wait_s("to");
        hi = 1;
        busy = 1'b0;
        repeat (12) begin
            tick();
            if (s === 1'b1) hi++;
            if (mem_rd !== 1'b0) busy = 1'b1;
        end
        check("to_s_cycles", hi, 4);
        check("to_err", {31'b0, err}, 1);
        check("to_pc", {30'b0, pc}, 0);
        check("to_retired", {16'b0, retired}, 0);
        check("to_no_refetch", {31'b0, busy}, 0);
        run = 1'b0;
        ctrl_never = 1'b0;

        // PC wrap over random non-HALT program, run dropped during the 5th EXEC.
        reset_dut();
        for (int i = 0; i < 4; i++) mem[i] = rand_word();
        run = 1'b1;
        for (int k = 0; k < 5; k++) begin
            issue_one("wrap", mem[k % 4], k % 4, k, int'($urandom_range(1, 4)));
            if (k == 4) run = 1'b0;
        end
        wait_ret("wrap", 5);
        check("wrap_pc", {30'b0, pc}, 1);
        idle_quiet("wrap_stop", 10);

        // Random programs with a HALT at a random address.
        repeat (3) begin
            reset_dut();
            h = int'($urandom_range(0, 3));
            for (int i = 0; i < 4; i++) mem[i] = rand_word();
            mem[h] = {3'b111, 13'($urandom)};
            run = 1'b1;
            for (int i = 0; i < h; i++)
                issue_one("rnd", mem[i], i, i, int'($urandom_range(1, 4)));
            wait_halt("rnd");
            check("rnd_pc", {30'b0, pc}, h);
            check("rnd_retired", {16'b0, retired}, h);
            check("rnd_ir", {16'b0, instr}, {16'b0, mem[h]});
            idle_quiet("rnd_halted", 6);
            run = 1'b0;
        end

        // Asynchronous reset in the middle of EXEC.
        reset_dut();
        mem[0] = 16'hD105; mem[1] = 16'hA0A0;
        run = 1'b1;
        issue_one("ar0", 16'hD105, 0, 0, 2);
        wait_ret("ar0", 1);
        issue_one("ar1", 16'hA0A0, 1, 1, 6);
        #2 reset = 1'b0;
        #1;
        check("ar_s", {31'b0, s}, 0);
        check("ar_pc", {30'b0, pc}, 0);
        check("ar_retired", {16'b0, retired}, 0);
        check("ar_halted", {31'b0, halted}, 0);
        check("ar_err", {31'b0, err}, 0);
        run = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        run = 1'b1;
        begin
            int n = 0;
            while (mem_rd !== 1'b1 && n < 50) begin tick(); n++; end
        end
        check("ar_refetch_rd", {31'b0, mem_rd}, 1);
        check("ar_refetch_addr", {30'b0, mem_addr}, 0);
        issue_one("ar2", 16'hD105, 0, 0, 1);
        run = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Instruction-issue initiator for `fsm_controller`; drives the other end of its s/w start/wait handshake.
- Fetches 16-bit instructions from a synchronous instruction memory (1-cycle read latency) and holds them in an instruction register (IR).
- Presents opcode/op to the controller, pulses `s`, waits for `w` to signal completion, then advances the PC.
- Sits between instruction memory and `fsm_controller`; IR also feeds the datapath decoder.

Parameters:
- PC_W, 8, program counter / memory address width
- TIMEOUT, 64, max cycles `s` may stay high without the controller dropping `w`

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = reset)
- run  in  1  level enable; 1 = fetch and issue, 0 = stop after the current instruction
- mem_rd  out  1  instruction-memory read strobe
- mem_addr  out  PC_W  read address
- mem_rdata  in  16  read data, valid the cycle after mem_rd
- s  out  1  start to controller
- w  in  1  controller wait/idle (1 = idle, ready for s)
- instr  out  16  IR contents
- opcode  out  3  instr[15:13]
- op  out  2  instr[12:11]
- pc  out  PC_W  current PC
- retired  out  16  count of completed instructions
- halted  out  1  HALT executed (sticky)
- err  out  1  handshake timeout (sticky)

Behaviour:
- Reset (async, reset=0): state=IDLE; s=0, mem_rd=0, mem_addr=0, pc=0, instr=0, opcode=0, op=0, retired=0, halted=0, err=0; timeout counter=0. Asserting reset mid-instruction aborts immediately with the same values.
- All outputs are registered or decoded from the registered state; none depend combinationally on w or mem_rdata.
- IDLE: if run=1 and halted=0 and err=0 -> FETCH; else stay.
- FETCH (1 cycle): mem_rd=1, mem_addr=pc -> LOAD.
- LOAD (1 cycle): IR <= mem_rdata at end of cycle.
  - If mem_rdata[15:13]==3'b111 (HALT) -> HALT.
  - Otherwise -> READY.
- READY: wait for w=1, then -> START. s=0 in this state.
- START: s=1; timeout counter increments each cycle.
  - On first cycle sampling w=0 -> EXEC; s deasserts in EXEC; counter clears.
  - If counter reaches TIMEOUT with w still 1: err<=1, s<=0 -> IDLE.
- EXEC: s=0; wait for w=1 (controller back in wait), then -> NEXT. No timeout in EXEC.
- NEXT (1 cycle): pc<=pc+1, wrapping from 2^PC_W-1 to 0; retired<=retired+1, saturating at 16'hFFFF.
  - run=1 -> FETCH; run=0 -> IDLE.
- HALT: halted<=1; pc not incremented; retired not incremented; s stays 0 -> IDLE. IDLE does not leave while halted=1; only reset clears it.
- run=0 in any state other than IDLE does not abort; the check happens only in NEXT.
- opcode/op/instr always reflect IR, and are stable from the START cycle through EXEC.
- Minimum latency: run rising in IDLE with w=1 gives s=1 four edges later (IDLE->FETCH->LOAD->READY->START).
- Minimum per-instruction loop: 6 cycles plus controller execution time.

Decomposition:
- Shared package `cpu_pkg`:
  - Opcode constants OP_MOV=3'b110, OP_ALU=3'b101, OP_HALT=3'b111.
  - Sequencer state enum (IDLE, FETCH, LOAD, READY, START, EXEC, NEXT, HALT).
  - Field-slice helpers for opcode/op.
- Single module; the timeout counter stays inline. No sub-module is warranted.

Test Plan:
- Basic issue:
  - Stimulus: mem[0]=16'hD105, run=1, controller model drops w one cycle after s and raises it 3 cycles later.
  - Required: mem_rd with addr 0; opcode=110, op=10; s high exactly 1 cycle; after completion pc=1 and retired=1.
- Sequential program:
  - Stimulus: mem[0..2] = 16'hD001, 16'hA0A0, 16'hE000.
  - Required: two s pulses with opcodes 110 then 101; HALT fetched at pc=2; halted=1; pc stays 2; retired=2; no third s pulse.
- Backpressure:
  - Stimulus: hold w=0 for 5 cycles after LOAD.
  - Required: sequencer holds in READY with s=0; s rises the cycle after w=1.
- Timeout:
  - Stimulus: TIMEOUT=4; controller never drops w.
  - Required: s high 4 cycles, then s=0, err=1, state IDLE; pc and retired unchanged.
- PC wrap and run-stop:
  - Stimulus: PC_W=2, run held to execute 5 non-HALT instructions.
  - Required: pc sequence 0,1,2,3,0,1.
  - Stimulus: drop run during EXEC of the 5th instruction.
  - Required: that instruction completes, pc advances, next state IDLE, no further mem_rd.
- Async reset mid-EXEC:
  - Stimulus: pull reset=0 between clock edges while in EXEC.
  - Required: s, pc, retired, halted, err all 0 immediately, without waiting for a clock edge; after release, fetch restarts at address 0.
